// File: rtl/ram_q_pkg.sv
// Shared defaults, FSM state type and lane-slice helpers
// for the multi-lane Q-matrix scratch RAM.
package ram_q_pkg;

    localparam int RAM_Q_LANES = 64;
    localparam int RAM_Q_AW    = 9;
    localparam int RAM_Q_DW    = 19;
    localparam int RAM_Q_DEPTH = 512;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ram_q_state_e;

    // Top bit of lane `lane` inside a flat bus of `w`-bit lanes
    function automatic int unsigned lane_msb(int unsigned lane, int unsigned w);
        return w * (lane + 1) - 1;
    endfunction

    // Bottom bit of lane `lane` inside a flat bus of `w`-bit lanes
    function automatic int unsigned lane_lsb(int unsigned lane, int unsigned w);
        return w * lane;
    endfunction

endpackage

// File: rtl/ram_q_clr_seq.sv
// Clear sequencer: sweeps LANES entries per cycle from index 0
// after reset or a CLR pulse, then returns to normal operation.
module ram_q_clr_seq
    import ram_q_pkg::*;
#(
    parameter int LANES = RAM_Q_LANES,
    parameter int DEPTH = RAM_Q_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    output logic                   busy_o,
    output logic                   clr_we_o,
    output logic [$clog2(DEPTH):0] base_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    ram_q_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          last;

    assign cnt_d = cnt_q + CW'(LANES);
    assign last  = (32'(cnt_q) + 32'(LANES)) >= 32'(DEPTH);

    // Sweep FSM; a CLR seen while already clearing does not restart it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (last) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign clr_we_o = busy_q;
    assign base_o   = cnt_q;

endmodule

// File: rtl/ram_q_mlane.sv
// LANES-port gather/scatter RAM, registered read, highest lane wins.
// Define RAM_Q_BYPASS_EN to forward same-edge write data to reads.
module ram_q_mlane
    import ram_q_pkg::*;
#(
    parameter int LANES = RAM_Q_LANES,
    parameter int AW    = RAM_Q_AW,
    parameter int DW    = RAM_Q_DW,
    parameter int DEPTH = RAM_Q_DEPTH
) (
    input  logic                  CK,
    input  logic                  RST_N,
    input  logic                  CLR,
    output logic                  BUSY,
    input  logic [LANES-1:0]      WE,
    input  logic                  RE,
    input  logic [LANES*AW-1:0]   A,
    input  logic [LANES*DW-1:0]   D,
    input  logic                  OE,
    output logic [LANES*DW-1:0]   Q,
    output logic                  Q_VLD
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [AW:0]    DEPTH_W = (AW + 1)'(DEPTH);

    logic [AW-1:0]    a_w     [LANES];
    logic [DW-1:0]    d_w     [LANES];
    logic [LANES-1:0] a_ok;
    logic [31:0]      clr_sum [LANES];
    logic [AW-1:0]    clr_idx [LANES];
    logic [LANES-1:0] clr_ok;
    logic [DW-1:0]    q_d     [LANES];
    logic [DW-1:0]    q_q     [LANES];
    logic             vld_q;
    logic             busy;
    logic             clr_we;
    logic [CW-1:0]    base;
    logic [DW-1:0]    mem     [DEPTH];

    ram_q_clr_seq #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .clk_i    (CK),
        .rst_ni   (RST_N),
        .clr_i    (CLR),
        .busy_o   (busy),
        .clr_we_o (clr_we),
        .base_o   (base)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign a_w[g]     = A[lane_msb(g, AW) -: AW];
        assign d_w[g]     = D[lane_msb(g, DW) -: DW];
        assign a_ok[g]    = {1'b0, a_w[g]} < DEPTH_W;
        assign clr_sum[g] = 32'(base) + 32'(g);
        assign clr_ok[g]  = clr_sum[g] < 32'(DEPTH);
        assign clr_idx[g] = clr_sum[g][AW-1:0];
        assign Q[lane_msb(g, DW) -: DW] = OE ? q_q[g] : '0;
    end

    // Storage: sweep zeroes a LANES-wide window, else lanes write in
    // ascending order so the highest enabled lane lands last
    always_ff @(posedge CK) begin
        if (clr_we) begin
            for (int j = 0; j < LANES; j++) begin
                if (clr_ok[j]) mem[clr_idx[j]] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (WE[i] && a_ok[i]) mem[a_w[i]] <= d_w[i];
            end
        end
    end

    // Read data per lane; out-of-range lanes read as zero
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            q_d[i] = a_ok[i] ? mem[a_w[i]] : '0;
`ifdef RAM_Q_BYPASS_EN
            for (int j = 0; j < LANES; j++) begin
                if (WE[j] && a_ok[i] && (a_w[j] == a_w[i])) q_d[i] = d_w[j];
            end
`endif
        end
    end

    // Output register and valid flag; both frozen/low while clearing
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q <= 1'b0;
            for (int i = 0; i < LANES; i++) q_q[i] <= '0;
        end else begin
            vld_q <= RE && !busy;
            if (RE && !busy) begin
                for (int i = 0; i < LANES; i++) q_q[i] <= q_d[i];
            end
        end
    end

    assign BUSY  = busy;
    assign Q_VLD = vld_q;

endmodule
